energy_frame_tx: RTL and testbench

Serial transmitter for the converter's measurement path: accepts 8-bit converted-voltage samples from the data collector over a valid/ready interface, buffers them in a small FIFO, and sends each one off-chip as a 4-byte checksummed frame on a UART 8N1 line. It is the outbound end of the sample stream and lets an external logger or MCU read samples without sampling the parallel output pins.

---
 rtl/energy_frame_tx.sv | 168 ++++++++++++++++
 tb/tb_energy_frame_tx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/energy_frame_tx.sv
// UART 8N1 framer for converted-voltage samples: buffers samples in a small FIFO
// and sends each one as SYNC, SEQ, DATA, CHK with CHK = SYNC ^ SEQ ^ DATA.
//
// state     | meaning
// IDLE      | line high, waiting for ena and a buffered sample
// START     | start bit (0) of the current byte
// DATA_BITS | eight data bits, LSB first
// STOP      | stop bit (1); chooses the next byte, the next frame or IDLE
module energy_frame_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic       sample_ready,
  output logic       tx,
  output logic       busy,
  output logic       overflow,
  output logic [7:0] seq
);

  localparam int              PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              CNTW     = $clog2(FIFO_DEPTH + 1);
  localparam logic [15:0]     BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] FULL     = CNTW'(FIFO_DEPTH);
  localparam logic [7:0]      SYNC     = 8'hA5;

  typedef enum logic [1:0] {IDLE, START, DATA_BITS, STOP} state_t;

  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CNTW-1:0] count;
  logic [15:0]     bit_cnt;
  logic [2:0]      bit_idx;
  logic [1:0]      byte_idx;
  logic [7:0]      shift;
  logic [7:0]      data_q;
  logic [7:0]      chk_q;
  logic [7:0]      head;
  logic            push;
  logic            pop;
  logic            fifo_has;
  logic            bit_end;
  logic            frame_end;

  assign sample_ready = (count != FULL);
  assign push         = sample_valid && sample_ready;
  assign fifo_has     = (count != '0);
  assign head         = mem[rd_ptr];
  assign bit_end      = (bit_cnt == '0);
  assign frame_end    = (state == STOP) && bit_end && (byte_idx == 2'd3);
  // A frame may start from IDLE or chain directly off the last stop bit.
  assign pop          = ena && fifo_has && ((state == IDLE) || frame_end);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_in;
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (sample_valid && !sample_ready) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      seq      <= 8'h00;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shift    <= '0;
      data_q   <= '0;
      chk_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            data_q   <= head;
            chk_q    <= SYNC ^ seq ^ head;
            shift    <= SYNC;
            byte_idx <= 2'd0;
            bit_cnt  <= BIT_LAST;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt <= BIT_LAST;
            bit_idx <= 3'd0;
            tx      <= shift[0];
            state   <= DATA_BITS;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        DATA_BITS: begin
          if (bit_end) begin
            bit_cnt <= BIT_LAST;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            bit_cnt <= BIT_LAST;
            if (byte_idx != 2'd3) begin
              byte_idx <= byte_idx + 2'd1;
              tx       <= 1'b0;
              state    <= START;
              case (byte_idx)
                2'd0:    shift <= seq;
                2'd1:    shift <= data_q;
                default: shift <= chk_q;
              endcase
            end else begin
              seq <= seq + 8'd1;
              // Chained frame carries the already-incremented sequence number.
              if (pop) begin
                data_q   <= head;
                chk_q    <= SYNC ^ (seq + 8'd1) ^ head;
                shift    <= SYNC;
                byte_idx <= 2'd0;
                tx       <= 1'b0;
                state    <= START;
              end else begin
                tx    <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_energy_frame_tx.sv
// Bench for energy_frame_tx: frame-level reference model compared every cycle,
// plus a UART decoder whose bytes are checked against hand-computed frames.
module tb_energy_frame_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FL    = 40 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] sample_in = 8'h00;
  logic       sample_valid = 1'b0;
  logic       sample_ready;
  logic       tx;
  logic       busy;
  logic       overflow;
  logic [7:0] seq;

  int checks = 0;
  int errors = 0;

  energy_frame_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sample_in(sample_in),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .tx(tx),
    .busy(busy), .overflow(overflow), .seq(seq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of accepted samples, and an active frame that is
  // a 40-bit line image played out CPB cycles per bit.
  logic [7:0]  mq[$];
  bit          m_act, m_ovf, m_rdy, m_push, m_start;
  int          m_cyc;
  logic [39:0] m_fb;
  logic [7:0]  m_seq, m_din;

  function automatic logic [39:0] build(input logic [7:0] s, input logic [7:0] d);
    logic [7:0]  b [4];
    logic [39:0] f;
    b[0] = 8'hA5; b[1] = s; b[2] = d; b[3] = 8'hA5 ^ s ^ d;
    f = '0;
    for (int k = 0; k < 4; k++) begin
      f[10*k] = 1'b0;
      for (int i = 0; i < 8; i++) f[10*k+1+i] = b[k][i];
      f[10*k+9] = 1'b1;
    end
    return f;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_act = 0; m_cyc = 0; m_seq = 8'h00; m_ovf = 0; m_fb = '0;
    end else begin
      m_rdy = (mq.size() != DEPTH);
      if (sample_valid && !m_rdy) m_ovf = 1;
      m_push = sample_valid && m_rdy;
      m_din  = sample_in;
      if (m_act) begin
        if (m_cyc == FL - 1) begin
          m_act = 0;
          m_seq = m_seq + 8'd1;
        end else begin
          m_cyc++;
        end
      end
      m_start = !m_act && ena && (mq.size() != 0);
      if (m_start) begin
        m_fb  = build(m_seq, mq.pop_front());
        m_act = 1;
        m_cyc = 0;
      end
      if (m_push) mq.push_back(m_din);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("tx",           tx,           m_act ? m_fb[m_cyc / CPB] : 1'b1);
      chk("busy",         busy,         m_act);
      chk("sample_ready", sample_ready, mq.size() != DEPTH);
      chk("overflow",     overflow,     m_ovf);
      chk("seq",          seq,          m_seq);
    end
  end

  // UART decoder sampling mid-bit.
  logic [7:0] rxq[$];
  bit         rx_on;
  int         rx_t;
  logic [7:0] rx_b;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxq.delete();
      rx_on = 0; rx_t = 0;
    end else if (!rx_on) begin
      if (!tx) begin rx_on = 1; rx_t = 0; end
    end else begin
      rx_t++;
      if (rx_t == CPB*9 + CPB/2) begin
        chk("stop_bit", tx, 1'b1);
        rxq.push_back(rx_b);
        rx_on = 0;
      end else if (rx_t > CPB && (rx_t % CPB) == CPB/2) begin
        rx_b[rx_t / CPB - 1] = tx;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ena = 1'b0; sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string nm, input int bound);
    int t = 0;
    while (busy && t < bound) begin @(negedge clk); t++; end
    chk(nm, busy, 1'b0);
  endtask

  task automatic wait_bytes(input string nm, input int n, input int bound);
    int t = 0;
    while (rxq.size() < n && t < bound) begin @(negedge clk); t++; end
    chk(nm, rxq.size(), n);
  endtask

  task automatic chk_frame(input string nm, input int base, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    chk({nm, "_sync"}, (rxq.size() > base+0) ? rxq[base+0] : 8'hxx, b0);
    chk({nm, "_seq"},  (rxq.size() > base+1) ? rxq[base+1] : 8'hxx, b1);
    chk({nm, "_data"}, (rxq.size() > base+2) ? rxq[base+2] : 8'hxx, b2);
    chk({nm, "_chk"},  (rxq.size() > base+3) ? rxq[base+3] : 8'hxx, b3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_seq", seq, 8'h00);
    chk("rst_ready", sample_ready, 1'b1);
    rst_n = 1'b1;

    // Single frame and one-cycle latency
    @(negedge clk);
    ena = 1'b1;
    sample_valid = 1'b1; sample_in = 8'h3C;
    @(negedge clk);
    sample_valid = 1'b0;
    chk("lat_tx_before", tx, 1'b1);
    chk("lat_busy_before", busy, 1'b0);
    @(negedge clk);
    chk("lat_tx_start", tx, 1'b0);
    chk("lat_busy_start", busy, 1'b1);
    n = 0;
    while (busy && n < 1000) begin n++; @(negedge clk); end
    chk("single_busy_cycles", n, FL);
    chk("single_seq", seq, 8'h01);
    chk("single_nbytes", rxq.size(), 4);
    chk_frame("single", 0, 8'hA5, 8'h00, 8'h3C, 8'h99);

    // Back-to-back frames
    do_reset();
    ena = 1'b1;
    sample_valid = 1'b1; sample_in = 8'h3C;
    @(negedge clk);
    @(negedge clk);
    sample_valid = 1'b0;
    n = 0;
    while (busy && n < 1000) begin n++; @(negedge clk); end
    chk("b2b_busy_cycles", n, 2*FL);
    chk("b2b_nbytes", rxq.size(), 8);
    chk_frame("b2b_f0", 0, 8'hA5, 8'h00, 8'h3C, 8'h99);
    chk_frame("b2b_f1", 4, 8'hA5, 8'h01, 8'h3C, 8'h98);

    // Overflow with ena low
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sample_valid = 1'b1; sample_in = 8'h10 + 8'(i);
      @(negedge clk);
    end
    sample_valid = 1'b0;
    chk("ovf_ready", sample_ready, 1'b0);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_busy", busy, 1'b0);
    chk("ovf_tx", tx, 1'b1);
    ena = 1'b1;
    wait_bytes("ovf_nbytes", 16, 5*FL);
    for (int k = 0; k < 4; k++)
      chk_frame("ovf_f", 4*k, 8'hA5, 8'(k), 8'h10 + 8'(k), 8'hA5 ^ 8'(k) ^ (8'h10 + 8'(k)));
    wait_idle("ovf_idle", 200);
    chk("ovf_sticky", overflow, 1'b1);

    // ena dropped during byte1 with two samples queued
    do_reset();
    ena = 1'b1;
    sample_valid = 1'b1; sample_in = 8'h21;
    @(negedge clk);
    sample_in = 8'h22;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (50) @(negedge clk);
    ena = 1'b0;
    wait_idle("ena_idle", 400);
    repeat (100) @(negedge clk);
    chk("ena_hold_tx", tx, 1'b1);
    chk("ena_hold_busy", busy, 1'b0);
    chk("ena_hold_nbytes", rxq.size(), 4);
    chk_frame("ena_f0", 0, 8'hA5, 8'h00, 8'h21, 8'h84);
    ena = 1'b1;
    wait_bytes("ena_nbytes", 8, 2*FL);
    chk_frame("ena_f1", 4, 8'hA5, 8'h01, 8'h22, 8'h86);
    wait_idle("ena_idle2", 200);

    // Reset during DATA_BITS of byte2
    do_reset();
    ena = 1'b1;
    sample_valid = 1'b1; sample_in = 8'h77;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (95) @(negedge clk);
    chk("rmid_busy_before", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rmid_tx", tx, 1'b1);
    chk("rmid_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rmid_seq", seq, 8'h00);
    chk("rmid_ready", sample_ready, 1'b1);
    chk("rmid_overflow", overflow, 1'b0);
    repeat (200) @(negedge clk);
    chk("rmid_nbytes", rxq.size(), 0);
    chk("rmid_idle", busy, 1'b0);

    // Sequence wrap: 257 frames, data = frame index ^ 0x5A
    do_reset();
    ena = 1'b1;
    for (int i = 0; i < 257; i++) begin
      n = 0;
      while (!sample_ready && n < 2000) begin @(negedge clk); n++; end
      sample_valid = 1'b1; sample_in = 8'(i) ^ 8'h5A;
      @(negedge clk);
      sample_valid = 1'b0;
    end
    wait_bytes("wrap_nbytes", 257*4, 8*FL);
    chk_frame("wrap_f255", 255*4, 8'hA5, 8'hFF, 8'hA5, 8'hFF);
    chk_frame("wrap_f256", 256*4, 8'hA5, 8'h00, 8'h5A, 8'hFF);
    wait_idle("wrap_idle", 2*FL);
    chk("wrap_seq", seq, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
